gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
- Self-checking truth-table sweeper: drives every input combination of an N_IN-input gate under test and samples its output.
- Compares each sample against an internal golden model selected by a mode code.
- Reports error count, first failing vector and pass/fail.
- Parametrised, synthesisable replacement for hand-written per-gate directed benches; sits beside a combinational gate block in the bench or in on-chip self-test.

Parameters:
- N_IN, 2, number of gate inputs (1..8); sweep length is 2**N_IN vectors.
- HOLD, 1, cycles each vector is held before dut_y is sampled (>=1); covers settle time.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin sweep; honoured only when busy=0
- mode  in  3  golden function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF(bit0), 7 NOT(bit0)
- dut_y  in  1  output of gate under test, driven from vec_out
- vec_out  out  N_IN  current input vector to gate under test
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion
- y_valid  out  1  one-cycle pulse per sampled vector
- y_out  out  1  sampled dut_y, valid with y_valid
- y_exp  out  1  golden value for the same sample, valid with y_valid
- err_count  out  N_IN+1  mismatches in current/last sweep
- first_fail  out  N_IN  first mismatching vector; 0 if none
- pass  out  1  1 when last completed sweep had err_count==0; held until next start

Behaviour:
- Reset (rst=1 at an edge): state IDLE; every output 0 (vec_out, busy, done, y_valid, y_out, y_exp, err_count, first_fail, pass). Reset mid-sweep aborts immediately, no done pulse.
- FSM states: IDLE, RUN.
- IDLE -> RUN: edge where start=1.
  - mode is latched into mode_q; later mode changes are ignored until the next start.
  - Cleared at the same edge: vec_out=0, hold_cnt=0, err_count=0, first_fail=0, pass=0, fail_seen=0.
  - busy=1 from that edge.
- RUN:
  - hold_cnt increments each cycle.
  - At the edge where hold_cnt==HOLD-1: sample dut_y into y_out, compute y_exp=f(mode_q, vec_out), pulse y_valid for one cycle.
  - On mismatch: err_count+1. If fail_seen=0, first_fail<=vec_out and fail_seen<=1.
  - At that same edge: if vec_out is all ones, go to IDLE with busy<=0, done<=1 and pass<=(final err_count==0). Otherwise vec_out+1 and hold_cnt<=0.
- Timing: start sampled at edge k. Sample i (i=0..2**N_IN-1) occurs at edge k+(i+1)*HOLD. done is high during the cycle after edge k+2**N_IN*HOLD.
- err_count width N_IN+1 holds the maximum 2**N_IN. No saturation or wrap is possible.
- start while busy=1 is ignored. start in the same cycle as done-going-high's state update (IDLE next cycle) is honoured on the following edge.
- rst has priority over start.
- N_IN=1: AND/OR/XOR reduce over a single bit, so they behave as BUF; NAND/NOR/XNOR behave as NOT.
- Golden-model reductions apply over all N_IN bits; BUF and NOT use vec_out[0] only.

Decomposition:
- Package gate_sweep_pkg: mode codes (MODE_AND..MODE_NOT, 3-bit) and state encoding (ST_IDLE, ST_RUN).
- Sub-module nary_gate: combinational, parameter N_IN, inputs vec and mode, output y. Serves as the golden model and is reusable as a parametrised gate under test.

Test Plan:
- N_IN=2, HOLD=1, mode=2 (NAND), dut_y = NAND of vec_out -> 4 y_valid pulses, vectors 0,1,2,3, y_out=1,1,1,0; done 4 cycles after start edge; err_count=0, pass=1.
- N_IN=2, mode=2, dut_y tied 0 -> err_count=3, first_fail=0, pass=0; last sample (vec 3) matches.
- N_IN=3, HOLD=2, mode=4 (XOR), dut_y = XNOR of vec_out -> err_count=8, first_fail=0, done at start edge + 16 cycles.
- N_IN=2, mode=0, correct AND dut; start pulsed and mode changed to 1 mid-sweep -> no restart, golden stays AND, err_count=0, single done pulse.
- rst asserted at sample 2 of a mode=3 sweep -> all outputs 0 next cycle, no done; fresh start completes normally with pass=1.
- N_IN=1, mode=7 (NOT), dut_y = ~vec_out[0] -> 2 samples, y_exp=1,0, pass=1.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared mode codes and FSM state encoding for the gate truth-table sweeper.
package gate_sweep_pkg;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_NAND = 3'd2,
    MODE_NOR  = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_BUF  = 3'd6,
    MODE_NOT  = 3'd7
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/nary_gate.sv
// Combinational N-input gate selected by a mode code; golden model or gate under test.
module nary_gate
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] vec,
  input  logic [2:0]      mode,
  output logic            y
);

  always_comb begin
    y = 1'b0;
    case (mode_t'(mode))
      MODE_AND:  y = &vec;
      MODE_OR:   y = |vec;
      MODE_NAND: y = ~&vec;
      MODE_NOR:  y = ~|vec;
      MODE_XOR:  y = ^vec;
      MODE_XNOR: y = ~^vec;
      MODE_BUF:  y = vec[0];
      MODE_NOT:  y = ~vec[0];
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps all 2**N_IN input vectors of a gate under test, holding each HOLD cycles,
// and scores the sampled output against the nary_gate golden model.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int HOLD = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mode,
  input  logic            dut_y,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            y_valid,
  output logic            y_out,
  output logic            y_exp,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            pass
);

  localparam int             HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);

  state_t          state_q, state_d;
  logic [2:0]      mode_q;
  logic [HW-1:0]   hold_cnt;
  logic            fail_seen;
  logic            gold_y;
  logic            start_ok, sample_now, last_vec, mismatch;
  logic [N_IN:0]   err_next;

  nary_gate #(.N_IN(N_IN)) u_golden (
    .vec  (vec_out),
    .mode (mode_q),
    .y    (gold_y)
  );

  assign busy     = (state_q == ST_RUN);
  assign mismatch = (dut_y != gold_y);
  assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    sample_now = 1'b0;
    last_vec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_ok = start;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        sample_now = (hold_cnt == HOLD_LAST);
        last_vec   = &vec_out;
        if (sample_now && last_vec) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= '0;
      vec_out    <= '0;
      hold_cnt   <= '0;
      fail_seen  <= 1'b0;
      done       <= 1'b0;
      y_valid    <= 1'b0;
      y_out      <= 1'b0;
      y_exp      <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else begin
      done    <= 1'b0;
      y_valid <= 1'b0;
      if (start_ok) begin
        mode_q     <= mode;
        vec_out    <= '0;
        hold_cnt   <= '0;
        err_count  <= '0;
        first_fail <= '0;
        pass       <= 1'b0;
        fail_seen  <= 1'b0;
      end else if (state_q == ST_RUN) begin
        if (sample_now) begin
          y_out     <= dut_y;
          y_exp     <= gold_y;
          y_valid   <= 1'b1;
          err_count <= err_next;
          if (mismatch && !fail_seen) begin
            first_fail <= vec_out;
            fail_seen  <= 1'b1;
          end
          // pass uses err_next so a mismatch on the final vector is counted
          if (last_vec) begin
            done <= 1'b1;
            pass <= (err_next == '0);
          end else begin
            vec_out  <= vec_out + 1'b1;
            hold_cnt <= '0;
          end
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: three configurations checked every cycle
// against a time-indexed behavioural model, plus hand-computed sweep results.
module tb_gate_sweep_checker;

  localparam int NN[3] = '{2, 3, 1};
  localparam int HH[3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] mode = '0;
  logic       cmp_en = 1'b0;

  int kind[3] = '{default: 0};
  int gm[3]   = '{default: 0};

  int checks = 0;
  int failures = 0;

  logic [1:0] vec0; logic [2:0] vec1; logic [0:0] vec2;
  logic [2:0] err0; logic [3:0] err1; logic [1:0] err2;
  logic [1:0] ff0;  logic [2:0] ff1;  logic [0:0] ff2;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic yv0, yv1, yv2, yo0, yo1, yo2, ye0, ye1, ye2;
  logic pass0, pass1, pass2, dy0, dy1, dy2;

  always #5 clk = ~clk;

  function automatic bit golden(int md, int v, int n);
    int ones = $countones(v & ((1 << n) - 1));
    case (md)
      0: return ones == n;
      1: return ones != 0;
      2: return ones != n;
      3: return ones == 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      6: return (v & 1) == 1;
      default: return (v & 1) == 0;
    endcase
  endfunction

  assign dy0 = (kind[0] == 1) ? 1'b0 : golden(gm[0], int'(vec0), 2);
  assign dy1 = (kind[1] == 1) ? 1'b0 : golden(gm[1], int'(vec1), 3);
  assign dy2 = (kind[2] == 1) ? 1'b0 : golden(gm[2], int'(vec2), 1);

  gate_sweep_checker #(.N_IN(2), .HOLD(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .dut_y(dy0),
    .vec_out(vec0), .busy(busy0), .done(done0), .y_valid(yv0), .y_out(yo0),
    .y_exp(ye0), .err_count(err0), .first_fail(ff0), .pass(pass0));

  gate_sweep_checker #(.N_IN(3), .HOLD(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .dut_y(dy1),
    .vec_out(vec1), .busy(busy1), .done(done1), .y_valid(yv1), .y_out(yo1),
    .y_exp(ye1), .err_count(err1), .first_fail(ff1), .pass(pass1));

  gate_sweep_checker #(.N_IN(1), .HOLD(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .dut_y(dy2),
    .vec_out(vec2), .busy(busy2), .done(done2), .y_valid(yv2), .y_out(yo2),
    .y_exp(ye2), .err_count(err2), .first_fail(ff2), .pass(pass2));

  int o_vec[3], o_busy[3], o_done[3], o_yv[3], o_yo[3], o_ye[3], o_err[3], o_ff[3], o_pass[3];

  always_comb begin
    o_vec[0] = int'(vec0); o_vec[1] = int'(vec1); o_vec[2] = int'(vec2);
    o_busy[0] = int'(busy0); o_busy[1] = int'(busy1); o_busy[2] = int'(busy2);
    o_done[0] = int'(done0); o_done[1] = int'(done1); o_done[2] = int'(done2);
    o_yv[0] = int'(yv0); o_yv[1] = int'(yv1); o_yv[2] = int'(yv2);
    o_yo[0] = int'(yo0); o_yo[1] = int'(yo1); o_yo[2] = int'(yo2);
    o_ye[0] = int'(ye0); o_ye[1] = int'(ye1); o_ye[2] = int'(ye2);
    o_err[0] = int'(err0); o_err[1] = int'(err1); o_err[2] = int'(err2);
    o_ff[0] = int'(ff0); o_ff[1] = int'(ff1); o_ff[2] = int'(ff2);
    o_pass[0] = int'(pass0); o_pass[1] = int'(pass1); o_pass[2] = int'(pass2);
  end

  // Model: elapsed cycles since the accepted start decide which vector is sampled.
  int m_act[3] = '{default: 0}, m_t[3] = '{default: 0}, m_mode[3] = '{default: 0};
  int m_err[3] = '{default: 0}, m_ff[3] = '{default: 0}, m_pass[3] = '{default: 0};
  int m_done[3] = '{default: 0}, m_yv[3] = '{default: 0}, m_yo[3] = '{default: 0};
  int m_ye[3] = '{default: 0}, m_vec[3] = '{default: 0};

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int act, t, md, er, ff, ps, dn, yv, yo, ye, vc, i;
      act = m_act[d]; t = m_t[d]; md = m_mode[d]; er = m_err[d]; ff = m_ff[d];
      ps = m_pass[d]; yo = m_yo[d]; ye = m_ye[d]; vc = m_vec[d];
      dn = 0; yv = 0;
      if (rst) begin
        act = 0; t = 0; md = 0; er = 0; ff = 0; ps = 0; yo = 0; ye = 0; vc = 0;
      end else if (act == 0) begin
        if (start_v[d]) begin
          act = 1; t = 0; md = int'(mode); er = 0; ff = 0; ps = 0; vc = 0;
        end
      end else begin
        t = t + 1;
        vc = t / HH[d];
        if (t % HH[d] == 0) begin
          i  = t / HH[d] - 1;
          yv = 1;
          yo = (kind[d] == 1) ? 0 : int'(golden(gm[d], i, NN[d]));
          ye = int'(golden(md, i, NN[d]));
          if (yo != ye) begin
            if (er == 0) ff = i;
            er = er + 1;
          end
          if (i == (1 << NN[d]) - 1) begin
            act = 0; dn = 1; ps = (er == 0) ? 1 : 0; vc = i;
          end
        end
      end
      m_act[d] <= act; m_t[d] <= t; m_mode[d] <= md; m_err[d] <= er; m_ff[d] <= ff;
      m_pass[d] <= ps; m_done[d] <= dn; m_yv[d] <= yv; m_yo[d] <= yo; m_ye[d] <= ye;
      m_vec[d] <= vc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  int cap_yo[3] = '{default: 0}, cap_ye[3] = '{default: 0};

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("d%0d.vec_out", d), o_vec[d], m_vec[d]);
        chk($sformatf("d%0d.busy", d), o_busy[d], m_act[d]);
        chk($sformatf("d%0d.done", d), o_done[d], m_done[d]);
        chk($sformatf("d%0d.y_valid", d), o_yv[d], m_yv[d]);
        chk($sformatf("d%0d.err_count", d), o_err[d], m_err[d]);
        chk($sformatf("d%0d.first_fail", d), o_ff[d], m_ff[d]);
        chk($sformatf("d%0d.pass", d), o_pass[d], m_pass[d]);
        if (m_yv[d] != 0) begin
          chk($sformatf("d%0d.y_out", d), o_yo[d], m_yo[d]);
          chk($sformatf("d%0d.y_exp", d), o_ye[d], m_ye[d]);
        end
        if (m_act[d] == 1 && m_t[d] == 0) begin
          cap_yo[d] = 0; cap_ye[d] = 0;
        end else if (o_yv[d] != 0) begin
          cap_yo[d] = (cap_yo[d] << 1) | o_yo[d];
          cap_ye[d] = (cap_ye[d] << 1) | o_ye[d];
        end
      end
    end
  end

  task automatic run(input int d, input int md, input int kd, input int g,
                     input int exp_cyc, input int exp_err, input int exp_ff,
                     input int exp_pass, input bit disturb);
    int n;
    kind[d] = kd; gm[d] = g; mode = 3'(md);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    n = 0;
    while (o_done[d] == 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (disturb && n == 1) begin start_v[d] = 1'b1; mode = 3'd1; end
      else if (disturb && n == 2) start_v[d] = 1'b0;
    end
    start_v[d] = 1'b0;
    chk($sformatf("d%0d.done_latency", d), n, exp_cyc);
    chk($sformatf("d%0d.final_err", d), o_err[d], exp_err);
    chk($sformatf("d%0d.final_first_fail", d), o_ff[d], exp_ff);
    chk($sformatf("d%0d.final_pass", d), o_pass[d], exp_pass);
    @(negedge clk);
    chk($sformatf("d%0d.idle_busy", d), o_busy[d], 0);
    chk($sformatf("d%0d.idle_done", d), o_done[d], 0);
    chk($sformatf("d%0d.pass_held", d), o_pass[d], exp_pass);
  endtask

  initial begin
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d.reset_vec", d), o_vec[d], 0);
      chk($sformatf("d%0d.reset_busy", d), o_busy[d], 0);
      chk($sformatf("d%0d.reset_err", d), o_err[d], 0);
      chk($sformatf("d%0d.reset_pass", d), o_pass[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run(0, 2, 0, 2, 4, 0, 0, 1, 1'b0);
    chk("nand_y_out_seq", cap_yo[0], 'b1110);
    chk("nand_y_exp_seq", cap_ye[0], 'b1110);

    run(0, 2, 1, 2, 4, 3, 0, 0, 1'b0);
    chk("tied0_y_out_seq", cap_yo[0], 'b0000);

    run(1, 4, 0, 5, 16, 8, 0, 0, 1'b0);

    run(0, 0, 0, 0, 4, 0, 0, 1, 1'b1);
    chk("and_y_exp_seq", cap_ye[0], 'b0001);

    kind[0] = 0; gm[0] = 3; mode = 3'd3;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort_busy", o_busy[0], 0);
    chk("rst_abort_done", o_done[0], 0);
    chk("rst_abort_vec", o_vec[0], 0);
    chk("rst_abort_y_valid", o_yv[0], 0);
    chk("rst_abort_y_out", o_yo[0], 0);
    chk("rst_abort_err", o_err[0], 0);
    rst = 1'b0;
    @(negedge clk);
    run(0, 3, 0, 3, 4, 0, 0, 1, 1'b0);

    run(2, 7, 0, 7, 2, 0, 0, 1, 1'b0);
    chk("not_y_exp_seq", cap_ye[2], 'b10);
    chk("not_y_out_seq", cap_yo[2], 'b10);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
